// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_DATA  = 2'd2,
    ST_ABORT = 2'd3
  } arb_state_t;

  localparam logic [7:0] HDR_BASE   = 8'hA0;
  localparam logic [7:0] ABORT_BYTE = 8'hFF;

  // Next requester id after `id`, wrapping at n.
  function automatic logic [2:0] wrap_inc(input logic [2:0] id, input int unsigned n);
    if ({29'd0, id} + 32'd1 >= n) return 3'd0;
    return id + 3'd1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester lanes, TX FIFO write side and arbiter status in one bundle.
interface uart_tx_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic           busy;
  logic           abort_pulse;
  logic           tx_wr_en;
  logic [7:0]     tx_d_in;
  logic           tx_full;

  // Client / FIFO side.
  modport master (
    output req_valid, req_data, req_last, tx_full,
    input  req_ready, grant, busy, abort_pulse, tx_wr_en, tx_d_in
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, req_last, tx_full,
    output req_ready, grant, busy, abort_pulse, tx_wr_en, tx_d_in
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first request at or above ptr_i, wrapping.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  input  logic [2:0]   ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [2:0]   idx_o,
  output logic         any_o
);

  logic [3:0] cand;

  // Walk N candidates starting at ptr_i; the first requesting one wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_i} + 4'(k);
      if (cand >= 4'(N)) cand = cand - 4'(N);
      for (int j = 0; j < N; j++) begin
        if (!any_o && cand == 4'(j) && req_i[j]) begin
          gnt_o[j] = 1'b1;
          idx_o    = 3'(j);
          any_o    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-level round-robin arbiter in front of the UART TX FIFO write port.
// Each grant emits a header byte (HDR_BASE | id) then the owner's payload up
// to req_last; a stalled owner is cut off with ABORT_BYTE.
module uart_tx_arbiter #(
  parameter int         N           = 4,
  parameter logic [7:0] HDR_BASE    = uart_pkg::HDR_BASE,
  parameter logic [7:0] ABORT_BYTE  = uart_pkg::ABORT_BYTE,
  parameter int         STALL_LIMIT = 64
) (
  input logic               clk,
  input logic               reset,
  uart_tx_arbiter_if.slave  bus
);
  import uart_pkg::*;

  arb_state_t   state_q, state_d;
  logic [N-1:0] grant_q, grant_d;
  logic [2:0]   gid_q, gid_d;
  logic [2:0]   ptr_q, ptr_d;
  logic [7:0]   stall_q, stall_d;

  logic [N-1:0] pick_gnt;
  logic [2:0]   pick_idx;
  logic         pick_any;

  logic         sel_valid, sel_last;
  logic [7:0]   sel_data;

  logic [N-1:0] ready;
  logic         wr_en, abort;
  logic [7:0]   dout;

  rr_pick #(.N(N)) u_pick (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Mux out the owner's lane.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (gid_q == 3'(i)) begin
        sel_valid = bus.req_valid[i];
        sel_last  = bus.req_last[i];
        sel_data  = bus.req_data[i*8 +: 8];
      end
    end
  end

  // Next state and FIFO write; nothing is written or advanced while tx_full.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    stall_d = stall_q;
    ready   = '0;
    wr_en   = 1'b0;
    abort   = 1'b0;
    dout    = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_HDR;
          grant_d = pick_gnt;
          gid_d   = pick_idx;
        end
      end
      ST_HDR: begin
        if (!bus.tx_full) begin
          wr_en   = 1'b1;
          dout    = HDR_BASE | {5'd0, gid_q};
          state_d = ST_DATA;
          stall_d = '0;
        end
      end
      ST_DATA: begin
        for (int i = 0; i < N; i++) ready[i] = (gid_q == 3'(i)) && !bus.tx_full;
        if (sel_valid && !bus.tx_full) begin
          wr_en   = 1'b1;
          dout    = sel_data;
          stall_d = '0;
          if (sel_last) begin
            state_d = ST_IDLE;
            grant_d = '0;
            ptr_d   = wrap_inc(gid_q, N);
          end
        end else if (!sel_valid) begin
          // Only a silent owner counts toward the stall; FIFO backpressure does not.
          stall_d = stall_q + 8'd1;
          if (stall_q + 8'd1 == 8'(STALL_LIMIT)) state_d = ST_ABORT;
        end
      end
      ST_ABORT: begin
        if (!bus.tx_full) begin
          wr_en   = 1'b1;
          dout    = ABORT_BYTE;
          abort   = 1'b1;
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = wrap_inc(gid_q, N);
          stall_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset drops any message in flight without an abort byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gid_q   <= '0;
      ptr_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      stall_q <= stall_d;
    end
  end

  assign bus.req_ready   = ready;
  assign bus.grant       = grant_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.abort_pulse = abort;
  assign bus.tx_wr_en    = wr_en;
  assign bus.tx_d_in     = dout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, directed corner cases and random
// message traffic checked against a message-level round-robin model.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N(N)) bus();

  uart_tx_arbiter #(.N(N), .HDR_BASE(8'hA0), .ABORT_BYTE(8'hFF), .STALL_LIMIT(64)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  l;
    logic        f;
    logic        ewr;
    logic [7:0]  ed;
    logic [3:0]  eg;
    logic [3:0]  er;
    logic        eb;
  } vec_t;

  vec_t tbl[16];

  logic [8:0] lq[N][$];   // per-lane pending bytes {last, data}
  bit         hold[N];
  bit         midmsg[N];
  bit         rnd = 1'b0;
  logic [7:0] wq[$];      // bytes seen on the FIFO write port
  logic [7:0] expq[$];

  always @(negedge clk) if (rst_n && bus.tx_wr_en) wq.push_back(bus.tx_d_in);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.tx_full   = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_grant"}, bus.grant, 0);
    chk({nm, "_busy"}, bus.busy, 0);
    chk({nm, "_ready"}, bus.req_ready, 0);
    chk({nm, "_wr"}, bus.tx_wr_en, 0);
    chk({nm, "_dout"}, bus.tx_d_in, 0);
    chk({nm, "_abort"}, bus.abort_pulse, 0);
  endtask

  task automatic reset_all();
    rst_n = 1'b0;
    drive_idle();
    rnd = 1'b0;
    for (int i = 0; i < N; i++) begin
      lq[i].delete();
      hold[i] = 1'b0;
      midmsg[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wq.delete();
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (lq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: present lane heads after the edge, sample at negedge, pop accepted bytes.
  task automatic run_cycle();
    logic [N-1:0]   v, l;
    logic [8*N-1:0] d;
    @(posedge clk);
    #1;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < N; i++) begin
      if (rnd) hold[i] = midmsg[i] && ($urandom_range(0, 4) == 0);
      if (lq[i].size() > 0 && !hold[i]) begin
        v[i] = 1'b1;
        d[i*8 +: 8] = lq[i][0][7:0];
        l[i] = lq[i][0][8];
      end
    end
    bus.req_valid = v;
    bus.req_data  = d;
    bus.req_last  = l;
    bus.tx_full   = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
    @(negedge clk);
    chk("ready_only_owner", bus.req_ready & ~bus.grant, 0);
    chk("grant_onehot0", $onehot0(bus.grant), 1);
    for (int i = 0; i < N; i++) begin
      if (v[i] && bus.req_ready[i]) begin
        midmsg[i] = !l[i];
        void'(lq[i].pop_front());
      end
    end
  endtask

  task automatic run_done(input int bound, input string nm);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < bound) begin
      run_cycle();
      n++;
      done = all_empty() && !bus.busy;
    end
    chk({nm, "_done"}, done, 1);
  endtask

  // Reference: from rr pointer 0, each message goes to the first lane at or
  // above the pointer that still has one; pointer moves past the winner.
  task automatic build_exp();
    logic [8:0] m[N][$];
    logic [8:0] b;
    int p, j;
    bit found;
    expq.delete();
    for (int i = 0; i < N; i++) m[i] = lq[i];
    p = 0;
    do begin
      found = 1'b0;
      for (int k = 0; k < N && !found; k++) begin
        j = (p + k) % N;
        if (m[j].size() > 0) begin
          found = 1'b1;
          expq.push_back(8'hA0 | 8'(j));
          b = 9'h000;
          while (!b[8] && m[j].size() > 0) begin
            b = m[j].pop_front();
            expq.push_back(b[7:0]);
          end
          p = (j + 1) % N;
        end
      end
    end while (found);
  endtask

  task automatic cmp_wq(input string nm);
    chk({nm, "_count"}, wq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < wq.size(); i++)
      chk($sformatf("%s_byte%0d", nm, i), wq[i], expq[i]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, first, pulses, lc, gc;
    logic [3:0] g67;
    int nmsg, len;

    // Lane 2 sends 11,22,33; then lane 0 sends 10,20 with 5 full cycles.
    tbl[0]  = '{4'h4, 32'h0011_0000, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0};
    tbl[1]  = '{4'h4, 32'h0011_0000, 4'h0, 1'b0, 1'b1, 8'hA2, 4'h4, 4'h0, 1'b1};
    tbl[2]  = '{4'h4, 32'h0011_0000, 4'h0, 1'b0, 1'b1, 8'h11, 4'h4, 4'h4, 1'b1};
    tbl[3]  = '{4'h4, 32'h0022_0000, 4'h0, 1'b0, 1'b1, 8'h22, 4'h4, 4'h4, 1'b1};
    tbl[4]  = '{4'h4, 32'h0033_0000, 4'h4, 1'b0, 1'b1, 8'h33, 4'h4, 4'h4, 1'b1};
    tbl[5]  = '{4'h0, 32'h0000_0000, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0};
    tbl[6]  = '{4'h1, 32'h0000_0010, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0};
    tbl[7]  = '{4'h1, 32'h0000_0010, 4'h0, 1'b0, 1'b1, 8'hA0, 4'h1, 4'h0, 1'b1};
    for (int i = 8; i <= 12; i++)
      tbl[i] = '{4'h1, 32'h0000_0010, 4'h0, 1'b1, 1'b0, 8'h00, 4'h1, 4'h0, 1'b1};
    tbl[13] = '{4'h1, 32'h0000_0010, 4'h0, 1'b0, 1'b1, 8'h10, 4'h1, 4'h1, 1'b1};
    tbl[14] = '{4'h1, 32'h0000_0020, 4'h1, 1'b0, 1'b1, 8'h20, 4'h1, 4'h1, 1'b1};
    tbl[15] = '{4'h0, 32'h0000_0000, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0};

    drive_idle();
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    chk_zero("reset");

    // Vector table
    reset_all();
    for (int r = 0; r < 16; r++) begin
      @(posedge clk);
      #1;
      bus.req_valid = tbl[r].v;
      bus.req_data  = tbl[r].d;
      bus.req_last  = tbl[r].l;
      bus.tx_full   = tbl[r].f;
      @(negedge clk);
      chk($sformatf("vec%0d_wr", r), bus.tx_wr_en, tbl[r].ewr);
      chk($sformatf("vec%0d_dout", r), bus.tx_d_in, tbl[r].ed);
      chk($sformatf("vec%0d_grant", r), bus.grant, tbl[r].eg);
      chk($sformatf("vec%0d_ready", r), bus.req_ready, tbl[r].er);
      chk($sformatf("vec%0d_busy", r), bus.busy, tbl[r].eb);
      chk($sformatf("vec%0d_abort", r), bus.abort_pulse, 0);
    end

    // Fairness: every lane always has a one-byte message waiting.
    reset_all();
    for (int i = 0; i < N; i++)
      for (int m = 0; m < 3; m++) lq[i].push_back({1'b1, 8'(16 * i + m)});
    build_exp();
    run_done(200, "fair");
    cmp_wq("fair");

    // Stall abort: lane 1 goes silent after one payload byte.
    reset_all();
    lq[1].push_back(9'h055);
    lq[1].push_back(9'h166);
    n = 0;
    do begin run_cycle(); n++; end while (!midmsg[1] && n < 10);
    chk("stall_started", midmsg[1], 1);
    hold[1] = 1'b1;
    lq[0].push_back(9'h199);
    lq[2].push_back(9'h177);
    first = -1; pulses = 0; g67 = '0;
    for (int c = 1; c <= 75; c++) begin
      run_cycle();
      if (bus.abort_pulse) begin
        pulses++;
        if (first < 0) first = c;
      end
      if (c == 67) g67 = bus.grant;
    end
    chk("stall_abort_cycle", first, 65);
    chk("stall_abort_pulses", pulses, 1);
    chk("stall_next_grant", g67, 4'b0100);
    expq = '{8'hA1, 8'h55, 8'hFF, 8'hA2, 8'h77, 8'hA0, 8'h99};
    cmp_wq("stall");

    // Lane 3 requests while lane 0 is mid-message.
    reset_all();
    lq[0].push_back(9'h001);
    lq[0].push_back(9'h002);
    lq[0].push_back(9'h103);
    n = 0;
    do begin run_cycle(); n++; end while (!midmsg[0] && n < 10);
    lq[3].push_back(9'h133);
    lc = -1; gc = -1;
    for (int c = 1; c <= 20; c++) begin
      run_cycle();
      if (lc < 0 && lq[0].size() == 0) lc = c;
      if (gc < 0 && bus.grant == 4'b1000) gc = c;
    end
    chk("wait_lane0_done", lc > 0, 1);
    chk("wait_lane3_grant", gc, lc + 2);
    expq = '{8'hA0, 8'h01, 8'h02, 8'h03, 8'hA3, 8'h33};
    cmp_wq("wait");

    // Async reset in DATA, then priority restarts at lane 0.
    reset_all();
    lq[2].push_back(9'h1AA);
    run_done(20, "rst_pre");
    lq[2].push_back(9'h0B1);
    lq[2].push_back(9'h0B2);
    lq[2].push_back(9'h1B3);
    n = 0;
    do begin run_cycle(); n++; end while (!midmsg[2] && n < 10);
    chk("rst_in_data_busy", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    for (int i = 0; i < N; i++) begin
      lq[i].delete();
      midmsg[i] = 1'b0;
    end
    drive_idle();
    @(posedge clk);
    #1 rst_n = 1'b1;
    wq.delete();
    lq[1].push_back(9'h111);
    lq[3].push_back(9'h133);
    build_exp();
    run_done(40, "rst_post");
    cmp_wq("rst_post");

    // Random messages with random owner gaps and FIFO backpressure.
    for (int round = 0; round < 3; round++) begin
      reset_all();
      for (int i = 0; i < N; i++) begin
        nmsg = $urandom_range(1, 3);
        for (int m = 0; m < nmsg; m++) begin
          len = $urandom_range(1, 5);
          for (int b = 0; b < len; b++) lq[i].push_back({b == len - 1, 8'($urandom)});
        end
      end
      build_exp();
      rnd = 1'b1;
      run_done(3000, "rand");
      rnd = 1'b0;
      cmp_wq($sformatf("rand%0d", round));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
